// File: rtl/edge_pkg.sv
// Shared types and legal parameter ranges for the multi-channel edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    localparam int CHANNELS_MIN        = 1;
    localparam int CHANNELS_MAX        = 32;
    localparam int SYNC_STAGES_MIN     = 2;
    localparam int DEBOUNCE_CYCLES_MIN = 1;
    localparam int PULSE_WIDTH_MIN     = 1;

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, debounce filter, edge qualification, pulse stretch and sticky flag.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_WIDTH     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_signal,
    input  edge_mode_e mode,
    input  logic       sticky_clr,
    output logic       output_pulse,
    output logic       level,
    output logic       sticky
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW_W  = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW_W-1:0]  PW_LOAD = PW_W'(PULSE_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    logic                   prev_level;
    logic [CNT_W-1:0]       db_cnt;
    logic [PW_W-1:0]        pw_cnt;
    logic                   edge_event;

    assign s = sync_ff[SYNC_STAGES-1];

    // Edge qualification uses the live mode input, so a mode change applies from the next clock.
    always_comb begin
        edge_event = 1'b0;
        case (mode)
            EDGE_RISE: edge_event = level & ~prev_level;
            EDGE_FALL: edge_event = ~level & prev_level;
            EDGE_BOTH: edge_event = level ^ prev_level;
            default:   edge_event = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff      <= '0;
            level        <= 1'b0;
            prev_level   <= 1'b0;
            db_cnt       <= '0;
            pw_cnt       <= '0;
            output_pulse <= 1'b0;
            sticky       <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[SYNC_STAGES-2:0], input_signal};
            prev_level <= level;

            if (s == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // A new event reloads the stretch count so back-to-back events merge into one pulse.
            if (edge_event) begin
                output_pulse <= 1'b1;
                pw_cnt       <= PW_LOAD;
            end else if (pw_cnt != '0) begin
                pw_cnt <= pw_cnt - 1'b1;
            end else begin
                output_pulse <= 1'b0;
            end

            if (edge_event) begin
                sticky <= 1'b1;
            end else if (sticky_clr) begin
                sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Array of independent debounced edge-detect channels with stretched pulses and sticky flags.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_WIDTH     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   input_signal,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   sticky_clr,
    output logic [CHANNELS-1:0]   output_pulse,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   sticky
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("multi_edge_detector: CHANNELS out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("multi_edge_detector: SYNC_STAGES below minimum");
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
        $error("multi_edge_detector: DEBOUNCE_CYCLES below minimum");
    end
    if (PULSE_WIDTH < PULSE_WIDTH_MIN) begin : g_bad_pulse
        $error("multi_edge_detector: PULSE_WIDTH below minimum");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_WIDTH     (PULSE_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .input_signal (input_signal[i]),
            .mode         (edge_mode_e'(mode[2*i +: 2])),
            .sticky_clr   (sticky_clr[i]),
            .output_pulse (output_pulse[i]),
            .level        (level[i]),
            .sticky       (sticky[i])
        );
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised bench comparing two detector instances (debounce 4 and 1) against a behavioural model.
module tb_multi_edge_detector;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int PW  = 3;
    localparam int DB0 = 4;
    localparam int DB1 = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     in_sig;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     clr;
    logic [CH-1:0]     pulse_a, level_a, sticky_a;
    logic [CH-1:0]     pulse_b, level_b, sticky_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, per DUT instance and channel.
    bit m_pipe [2][CH][SS];
    bit m_lvl  [2][CH];
    bit m_plvl [2][CH];
    bit m_stk  [2][CH];
    int m_diff [2][CH];
    int m_last [2][CH];
    int cyc = 0;
    logic [CH-1:0] exp_pulse [2];
    logic [CH-1:0] exp_level [2];
    logic [CH-1:0] exp_stk   [2];

    always #5 clk = ~clk;

    multi_edge_detector #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB0), .PULSE_WIDTH(PW)
    ) dut_a (
        .clk(clk), .rst(rst), .input_signal(in_sig), .mode(mode), .sticky_clr(clr),
        .output_pulse(pulse_a), .level(level_a), .sticky(sticky_a)
    );

    multi_edge_detector #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB1), .PULSE_WIDTH(PW)
    ) dut_b (
        .clk(clk), .rst(rst), .input_signal(in_sig), .mode(mode), .sticky_clr(clr),
        .output_pulse(pulse_b), .level(level_b), .sticky(sticky_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural rules: the input reaches the filter SS edges after it is sampled; the level
    // flips once the filtered input has disagreed with it on D consecutive edges; an event is a
    // level change the mode asks for; the pulse is high for PW edges after the latest event.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    for (int k = 0; k < SS; k++) m_pipe[d][c][k] = 1'b0;
                    m_lvl[d][c]  = 1'b0;
                    m_plvl[d][c] = 1'b0;
                    m_stk[d][c]  = 1'b0;
                    m_diff[d][c] = 0;
                    m_last[d][c] = -1000;
                end else begin
                    bit s;
                    bit ev;
                    int db;
                    logic [1:0] md;
                    db = (d == 0) ? DB0 : DB1;
                    md = mode[2*c +: 2];
                    s  = m_pipe[d][c][SS-1];
                    case (md)
                        2'b00:   ev = m_lvl[d][c] && !m_plvl[d][c];
                        2'b01:   ev = !m_lvl[d][c] && m_plvl[d][c];
                        2'b10:   ev = m_lvl[d][c] != m_plvl[d][c];
                        default: ev = 1'b0;
                    endcase
                    m_plvl[d][c] = m_lvl[d][c];
                    if (s != m_lvl[d][c]) begin
                        m_diff[d][c]++;
                        if (m_diff[d][c] == db) begin
                            m_lvl[d][c]  = s;
                            m_diff[d][c] = 0;
                        end
                    end else begin
                        m_diff[d][c] = 0;
                    end
                    for (int k = SS-1; k > 0; k--) m_pipe[d][c][k] = m_pipe[d][c][k-1];
                    m_pipe[d][c][0] = in_sig[c];
                    if (ev) begin
                        m_last[d][c] = cyc;
                        m_stk[d][c]  = 1'b1;
                    end else if (clr[c]) begin
                        m_stk[d][c] = 1'b0;
                    end
                end
                exp_pulse[d][c] = (cyc - m_last[d][c]) < PW;
                exp_level[d][c] = m_lvl[d][c];
                exp_stk[d][c]   = m_stk[d][c];
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pulse_a",  32'(pulse_a),  32'(exp_pulse[0]));
        check("level_a",  32'(level_a),  32'(exp_level[0]));
        check("sticky_a", 32'(sticky_a), 32'(exp_stk[0]));
        check("pulse_b",  32'(pulse_b),  32'(exp_pulse[1]));
        check("level_b",  32'(level_b),  32'(exp_level[1]));
        check("sticky_b", 32'(sticky_b), 32'(exp_stk[1]));
    endtask

    initial begin
        int run3;
        rst    = 1'b1;
        in_sig = '0;
        clr    = '0;
        mode   = {2'b10, 2'b11, 2'b10, 2'b00};
        step();
        step();
        check("reset_pulse", 32'({pulse_a, pulse_b}), 32'h0);
        check("reset_sticky", 32'({sticky_a, sticky_b}), 32'h0);
        rst = 1'b0;
        step();

        // Clean rising edge on ch0: level at edge 5, pulse on edges 6..8, sticky from edge 6.
        in_sig[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (e == 4) check("ch0_level_e4", 32'(level_a[0]), 32'd0);
            if (e == 5) check("ch0_level_e5", 32'(level_a[0]), 32'd1);
            if (e == 5) check("ch0_pulse_e5", 32'(pulse_a[0]), 32'd0);
            if (e == 6) check("ch0_pulse_e6", 32'(pulse_a[0]), 32'd1);
            if (e == 6) check("ch0_sticky_e6", 32'(sticky_a[0]), 32'd1);
            if (e == 8) check("ch0_pulse_e8", 32'(pulse_a[0]), 32'd1);
            if (e == 9) check("ch0_pulse_e9", 32'(pulse_a[0]), 32'd0);
        end

        // Two edges two cycles apart on ch3 of the unfiltered instance: one merged 5-cycle pulse.
        in_sig[3] = 1'b1;
        step();
        step();
        in_sig[3] = 1'b0;
        run3 = pulse_b[3] ? 1 : 0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (pulse_b[3]) run3++;
        end
        check("ch3_merged_pulse_len", 32'(run3), 32'd5);
        check("ch3_filtered_level", 32'(level_a[3]), 32'd0);

        // Randomised traffic with bounces, mode changes, sticky clears and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) in_sig[c] = ~in_sig[c];
                if ($urandom_range(0, 199) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                clr[c] = ($urandom_range(0, 11) == 0);
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (legal minimum 2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a level is accepted (legal minimum 1; a value of 1 means no filtering).
REQ-004 SHALL have parameter PULSE_WIDTH, default 1, output pulse length in clk cycles (legal minimum 1).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port input_signal, input, CHANNELS bits, asynchronous raw inputs, one bit per channel.
REQ-008 SHALL have port mode, input, 2*CHANNELS bits, per-channel detect mode (2 bits per channel, channel i at bits [2i+1:2i]).
REQ-009 SHALL have port sticky_clr, input, CHANNELS bits, per-channel clear for sticky flags.
REQ-010 SHALL have port output_pulse, output, CHANNELS bits, registered event pulses.
REQ-011 SHALL have port level, output, CHANNELS bits, debounced stable level.
REQ-012 SHALL have port sticky, output, CHANNELS bits, latched "event seen" flags.

Function
REQ-013 Each channel SHALL pass input_signal through a SYNC_STAGES-deep flop chain; the last stage is the synchronised value s.
REQ-014 The debounce counter SHALL increment while s differs from level, and SHALL reset to 0 whenever s equals level.
REQ-015 When s differs from level and the counter equals DEBOUNCE_CYCLES-1, level SHALL take the value of s and the counter SHALL return to 0.
REQ-016 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-017 Mode encoding: 00 = rising edge of level, 01 = falling edge, 10 = either edge, 11 = disabled.
REQ-018 An edge event SHALL be a change of level between consecutive cycles that matches the mode value sampled in the same cycle; a mode change takes effect on the next clock.
REQ-019 Edge-to-pulse latency: when input_signal is first sampled at its new value on edge 0 and is held, level SHALL change on edge SYNC_STAGES-1+DEBOUNCE_CYCLES and output_pulse SHALL go high on edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-020 output_pulse SHALL stay high for exactly PULSE_WIDTH cycles, timed by a per-channel stretch counter of width $clog2(PULSE_WIDTH+1).
REQ-021 An event that occurs while a pulse is active SHALL restart the stretch count, so the pulse stays high for PULSE_WIDTH cycles after the last event; the pulse SHALL NOT drop between the two events.
REQ-022 Mode 11 SHALL suppress output_pulse and sticky updates; level SHALL continue to track the input.
REQ-023 Switching a channel to mode 11 while its pulse is active SHALL let the current pulse finish.
REQ-024 sticky[i] SHALL be set on the clock after an event on channel i, and cleared on the clock after sticky_clr[i] is high.
REQ-025 If an event and sticky_clr[i] occur in the same cycle, set SHALL win.
REQ-026 Channels SHALL be fully independent; simultaneous events on any subset of channels SHALL all be reported in the same cycle.

Reset
REQ-027 On rst high at a clock edge, the following SHALL all be 0 on that edge: sync flops, level, previous-level register, both counters, output_pulse and sticky.
REQ-028 Because level resets to 0, an input held high through reset release SHALL produce one rising event, with the latency of REQ-019 counted from the first non-reset edge.
REQ-029 A reset asserted during debounce or during a pulse SHALL abort that operation with no residual pulse afterwards.

Structure
REQ-030 A shared package edge_pkg SHALL hold the mode typedef (enum: EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and the legal-range constants.
REQ-031 Per-channel logic SHALL be a sub-module edge_channel, instantiated CHANNELS times in a generate loop.
REQ-032 Illegal parameter values SHALL trigger an elaboration-time assertion.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_WIDTH=3)
REQ-033 Ch0 mode 00, input 0->1 sampled on edge 0 and held -> level[0] rises on edge 5, output_pulse[0] high on edges 6-8, then low; sticky[0] set on edge 6.
REQ-034 Ch1 mode 10, input high for 3 cycles then low (bounce) -> level[1] and output_pulse[1] stay 0; then a clean 1->0->1 with 10-cycle holds -> two 3-cycle pulses.
REQ-035 Ch2 mode 11, clean toggles -> level[2] follows with 5-cycle latency; output_pulse[2] and sticky[2] stay 0.
REQ-036 Ch3 mode 10 with DEBOUNCE_CYCLES overridden to 1, two edges 2 cycles apart -> output_pulse[3] held high continuously for 5 cycles (stretch restart).
REQ-037 sticky_clr[0] asserted in the same cycle as a new event on ch0 -> sticky[0] stays 1; asserted alone -> sticky[0] is 0 on the next edge.
REQ-038 All inputs high, rst pulsed for 1 cycle mid-pulse -> all outputs 0 on the reset edge, then one rising pulse per channel in mode 00 or 10, 6 edges after reset release.
